// File: rtl/apb_master.sv
// APB3 initiator: each accepted command becomes one SETUP->ACCESS transfer and one response pulse.
// Optional ACCESS watchdog is compiled in when APB_MASTER_TIMEOUT_EN is defined.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and cmd_ready are
// both high, and the requester holds the command stable until then. A response is a
// single-cycle rsp_valid pulse with no backpressure. rsp_rdata/rsp_err/rsp_timeout hold
// until the next response.

module apb_master #(
  parameter int addrWidth     = 32,
  parameter int dataWidth     = 8,
  parameter int timeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [addrWidth-1:0] paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(timeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rsp_timeout_q, rsp_timeout_d;

  assign cnt_inc     = cnt_q + CntW'(1);
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = S_SETUP;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          psel_d   = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          // pready wins even on the cycle the watchdog would have fired
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(timeoutCycles)) begin
            state_d       = S_DONE;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: vector table, timer-style slave polling, randomized traffic
// against a transaction-level memory model, watchdog and asynchronous reset sequences.

module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_write;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata  = 8'h00;
  logic          pready  = 1'b0;
  logic          pslverr = 1'b0;
  logic [1:0]    dbg_state;

  apb_master #(.addrWidth(AW), .dataWidth(DW), .timeoutCycles(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model: memory plus a timer at address 0 (goal at address 1)
  logic [7:0] slv_mem [256] = '{default: 8'h00};
  int  slv_waits = 0;
  bit  slv_err   = 1'b0;
  bit  slv_stuck = 1'b0;
  int  wait_cnt  = 0;
  int  t_start   = 0;
  bit  t_running = 1'b0;

  function automatic logic [7:0] timer_status();
    if (!t_running) return 8'h00;
    if (cyc - t_start >= int'(slv_mem[1])) return 8'h08;
    return 8'h04;
  endfunction

  always @(negedge clk) begin
    if (psel && penable) begin
      if (slv_stuck || wait_cnt < slv_waits) begin
        pready   = 1'b0;
        wait_cnt = wait_cnt + 1;
      end else begin
        pready  = 1'b1;
        pslverr = slv_err;
        if (pwrite) begin
          prdata = 8'($urandom);
          if (!slv_err) begin
            if (paddr[7:0] == 8'h00 && pwdata[0]) begin
              t_running = 1'b1;
              t_start   = cyc;
            end
            slv_mem[paddr[7:0]] = pwdata;
          end
        end else begin
          prdata = (paddr[7:0] == 8'h00) ? timer_status() : slv_mem[paddr[7:0]];
        end
      end
    end else begin
      pready   = 1'b0;
      pslverr  = 1'b0;
      prdata   = 8'($urandom);
      wait_cnt = 0;
    end
  end

  // scoreboard: expected {err, rdata} per transaction and a reference memory
  logic [8:0] exp_q [$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic start_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] wd);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = 8'($urandom);
  endtask

  // lat is the cycle offset of rsp_valid from the handshake (zero-wait slave: 3)
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                        input int waits, input bit err,
                        output logic [7:0] rdata, output logic e, output logic to,
                        output int lat);
    bit hold_ok, rise_ok;
    slv_waits = waits;
    slv_err   = err;
    start_cmd(wr, addr, wd);
    hold_ok = 1'b1;
    rise_ok = (psel === 1'b1 && penable === 1'b0 && cmd_ready === 1'b0);
    lat = -1; rdata = 'x; e = 'x; to = 'x;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (rsp_valid === 1'b1) begin
        lat = i; rdata = rsp_rdata; e = rsp_err; to = rsp_timeout;
        if (psel !== 1'b0 || penable !== 1'b0) hold_ok = 1'b0;
        break;
      end
      if (i == 2 && !(psel === 1'b1 && penable === 1'b1)) rise_ok = 1'b0;
      if (psel !== 1'b1 || paddr !== addr || pwrite !== wr || pwdata !== (wr ? wd : 8'h00))
        hold_ok = 1'b0;
    end
    check("psel_penable_rise", 32'(rise_ok), 32'h1);
    check("apb_hold_stable", 32'(hold_ok), 32'h1);
    @(posedge clk); #1;
    check("rsp_single_pulse", {30'h0, rsp_valid, cmd_ready}, 32'h1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    int          waits;
    bit          err;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    logic [7:0] rd;
    logic       e, to;
    int         lat;
    logic [8:0] exp;
    logic [1:0] st;
    bit         ok;

    vecs[0] = '{1'b1, 32'h0000_0001, 8'd25, 0, 1'b0, 8'h00,  1'b0};
    vecs[1] = '{1'b0, 32'h0000_0001, 8'h00, 0, 1'b0, 8'd25,  1'b0};
    vecs[2] = '{1'b1, 32'h0000_0003, 8'h77, 0, 1'b1, 8'h00,  1'b1};
    vecs[3] = '{1'b0, 32'h0000_0003, 8'h00, 1, 1'b0, 8'h00,  1'b0};
    vecs[4] = '{1'b1, 32'h0000_0014, 8'hA5, 0, 1'b0, 8'h00,  1'b0};
    vecs[5] = '{1'b0, 32'h0000_0014, 8'h00, 3, 1'b0, 8'hA5,  1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FF10, 8'h5A, 2, 1'b0, 8'h00,  1'b0};
    vecs[7] = '{1'b0, 32'h0000_0010, 8'h00, 0, 1'b1, 8'h5A,  1'b1};
    vecs[8] = '{1'b1, 32'h1234_5602, 8'hFF, 1, 1'b0, 8'h00,  1'b0};
    vecs[9] = '{1'b0, 32'h0000_0002, 8'h00, 0, 1'b0, 8'hFF,  1'b0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    #12;
    check("reset_ctrl_outs", {25'h0, cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}, 32'h0);
    check("reset_paddr", paddr, 32'h0);
    check("reset_data_outs", {16'h0, pwdata, rsp_rdata}, 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(cmd_ready), 32'h1);
    check("state_after_reset", 32'(dbg_state), 32'h0);

    // vector table
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits, vecs[i].err, rd, e, to, lat);
      if (vecs[i].wr && !vecs[i].err) ref_mem[vecs[i].addr[7:0]] = vecs[i].wd;
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_timeout", i), 32'(to), 32'h0);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(3 + vecs[i].waits));
    end

    // timer: start, then poll status until done
    do_txn(1'b1, 32'h0, 8'h01, 0, 1'b0, rd, e, to, lat);
    check("timer_start_err", 32'(e), 32'h0);
    do_txn(1'b0, 32'h0, 8'h00, 0, 1'b0, rd, e, to, lat);
    check("timer_running", 32'(rd[3:2]), 32'h1);
    st = rd[3:2];
    for (int p = 0; p < 20 && st != 2'd2; p++) begin
      do_txn(1'b0, 32'h0, 8'h00, 0, 1'b0, rd, e, to, lat);
      st = rd[3:2];
    end
    check("timer_done", 32'(st), 32'h2);

    // randomized traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      bit         wr, er;
      logic [31:0] a;
      logic [7:0] wd;
      int         w;
      wr = 1'($urandom_range(0, 1));
      a  = {24'($urandom), 8'($urandom_range(8, 63))};
      wd = 8'($urandom);
      w  = $urandom_range(0, 3);
      er = ($urandom_range(0, 7) == 0);
      exp_q.push_back(wr ? {er, 8'h00} : {er, ref_mem[a[7:0]]});
      if (wr && !er) ref_mem[a[7:0]] = wd;
      do_txn(wr, a, wd, w, er, rd, e, to, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_rsp", t), {23'h0, e, rd}, {23'h0, exp});
      check($sformatf("rand%0d_timeout", t), 32'(to), 32'h0);
      check($sformatf("rand%0d_latency", t), 32'(lat), 32'(3 + w));
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // pready on the last permitted ACCESS cycle completes normally
    do_txn(1'b0, 32'h5, 8'h00, 15, 1'b0, rd, e, to, lat);
    check("limit_pready_rsp", {22'h0, to, e, rd}, 32'h0);
    check("limit_pready_latency", 32'(lat), 32'd18);
    slv_stuck = 1'b1;
    do_txn(1'b0, 32'h6, 8'h00, 0, 1'b0, rd, e, to, lat);
    check("timeout_rsp", {22'h0, to, e, rd}, 32'h300);
    check("timeout_latency", 32'(lat), 32'd18);
    start_cmd(1'b0, 32'h7, 8'h00);
    repeat (4) @(posedge clk);
`else
    slv_stuck = 1'b1;
    start_cmd(1'b0, 32'h7, 8'h00);
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (psel !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
    end
    check("no_watchdog_hang", 32'(ok), 32'h1);
`endif

    // asynchronous reset in the middle of ACCESS
    @(posedge clk); #2;
    check("pre_reset_access", {30'h0, psel, penable}, 32'h3);
    reset = 1'b0;
    #1;
    check("async_psel_drop", {30'h0, psel, penable}, 32'h0);
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) ok = 1'b0;
    end
    slv_stuck = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mid_reset", 32'(cmd_ready), 32'h1);
    repeat (3) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("no_rsp_for_aborted", 32'(ok), 32'h1);

    do_txn(1'b0, 32'h1, 8'h00, 0, 1'b0, rd, e, to, lat);
    check("recovery_read", {22'h0, to, e, rd}, 32'd25);
    check("recovery_latency", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
Synthesizable APB initiator that turns single-word command requests into APB3 transfers. It drives the timer peripheral and any other APB slave in the design, replacing bench-driven bus tasks in RTL. Each accepted command produces exactly one SETUP→ACCESS transfer and exactly one response pulse carrying read data and error status.

Parameters:
- addrWidth, 32, width of cmd_addr and paddr.
- dataWidth, 8, width of write and read data paths.
- timeoutCycles, 16, maximum number of ACCESS cycles with pready low before abort. Used only with APB_MASTER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high at a clock edge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  addrWidth  target address.
- cmd_wdata  input  dataWidth  write data.
- rsp_valid  output  1  one-cycle pulse when a transfer completes.
- rsp_rdata  output  dataWidth  captured prdata; 0 for writes and for timeouts.
- rsp_err  output  1  captured pslverr, or 1 on timeout.
- rsp_timeout  output  1  1 when the transfer was aborted by the watchdog.
- paddr  output  addrWidth  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  dataWidth  APB write data.
- prdata  input  dataWidth  APB read data.
- pready  input  1  APB slave ready.
- pslverr  input  1  APB slave error.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready, which is 0 during reset and 1 in the first cycle after release.
  - psel and penable drop immediately, even mid-transfer. No response is issued for an aborted transfer.
  - The timeout counter clears.
- States: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On handshake, register cmd_addr into paddr and cmd_write into pwrite.
  - Register pwdata = cmd_wdata for writes and 0 for reads.
  - Next state is SETUP.
- SETUP:
  - psel=1, penable=0, cmd_ready=0.
  - Next state is always ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - When pready=1 is sampled: capture pslverr into rsp_err, and capture prdata into rsp_rdata if reading (0 if writing). Next state is DONE.
  - While pready=0: remain in ACCESS with all APB outputs held stable.
- DONE:
  - psel=0, penable=0, rsp_valid=1 for exactly this cycle, cmd_ready=0.
  - Next state is IDLE.
- Latency: handshake at edge N gives SETUP in N+1, ACCESS in N+2, and rsp_valid in N+3 for a zero-wait slave. Each wait state adds one cycle. The next command can be accepted at N+4 at the earliest.
- Stability: paddr, pwrite and pwdata do not change from SETUP through the end of ACCESS. They retain their last values in IDLE and DONE.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next DONE. They are only meaningful while rsp_valid=1.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold the command.
- A response is never dropped, and the block has no response backpressure.
- pslverr=1 with pready=1 is a normal completion with rsp_err=1.

Optional Feature:
- APB_MASTER_TIMEOUT_EN defined:
  - A counter of width $clog2(timeoutCycles+1) increments on each ACCESS cycle with pready=0. It clears on entry to SETUP.
  - When the counter reaches timeoutCycles while pready is still 0, the transfer is aborted. The next state is DONE with rsp_err=1, rsp_timeout=1 and rsp_rdata=0, and psel/penable deassert in that DONE cycle.
  - If pready=1 arrives in the same cycle the count reaches the limit, pready wins and the transfer completes normally.
- APB_MASTER_TIMEOUT_EN undefined:
  - There is no counter; ACCESS waits indefinitely.
  - rsp_timeout is tied to 0.

Test Plan:
- Write then read to timer address 1 (goal): write 25 to the goal register, then read address 1. Required: psel rises the cycle after the handshake, penable one cycle later, rsp_valid 3 cycles after each handshake, read rsp_rdata=25, rsp_err=0.
- Start the timer and poll status: write 8'h01 to address 0, then read address 0 repeatedly. Required: state bits [3:2] read 1 while running, then 2 once 25 cycles have elapsed.
- Wait-state slave model (pready low for 3 ACCESS cycles, prdata=8'hA5): required rsp_valid at handshake+6, rsp_rdata=8'hA5, with paddr, pwrite and pwdata stable throughout.
- pslverr: slave returns pslverr=1 with pready=1 on a write to address 3. Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout (macro defined, timeoutCycles=16, pready stuck at 0): required rsp_valid at handshake+18 with rsp_err=1 and rsp_timeout=1. With the macro undefined, psel stays 1 for 100 cycles and no rsp_valid appears.
- Reset asserted during ACCESS: psel and penable go to 0 without waiting for a clock edge, no rsp_valid appears, and cmd_ready=1 in the first cycle after reset release.
